hex_display_scanner: RTL and testbench
======================================

Name: hex_display_scanner

Overview:
- Time-multiplexes a multi-digit hex value onto a shared 7-segment bus. Sits directly upstream of the team's combinational hex-to-7-segment decoder.
- Each scan slot presents one 4-bit digit nibble to the decoder and drives the matching active-low anode enable.
- Adds dead-time between digits against ghosting, optional leading-zero blanking, and tear-free value updates at frame boundaries.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- ON_CYCLES, 50000, clk cycles each digit's anode is driven (>=2).
- DEAD_CYCLES, 500, clk cycles with all anodes off between digits (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable; 0 blanks the display.
- load  input  1  one-cycle strobe that captures value.
- value  input  4*NUM_DIGITS  hex digits; digit 0 = bits [3:0] (rightmost).
- blank_lz  input  1  1 = suppress leading zero digits; digit 0 is never suppressed.
- digit  output  4  nibble for the decoder input.
- anode_n  output  NUM_DIGITS  active-low digit enables; bit i = digit i.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset: state=IDLE, idx=0, cnt=0, disp_reg=0, shadow=0, pending=0, digit=0, anode_n=all ones, frame_done=0.
- FSM states:
  - IDLE: anodes off. If en=1, go to ON next cycle with idx=0, cnt=0.
  - ON: anode_n[idx]=0 unless idx is blanked; digit=disp_reg nibble idx. Stays ON_CYCLES cycles, then goes to DEAD.
  - DEAD: anode_n all ones for DEAD_CYCLES cycles, then returns to ON.
- Index advance:
  - On the ON->DEAD edge, idx advances (wraps NUM_DIGITS-1 -> 0).
  - digit updates at entry to DEAD, so the nibble is settled for the whole dead-time before the next anode asserts.
- Frame boundary:
  - Is the ON->DEAD edge where idx wraps to 0.
  - frame_done=1 for exactly that one cycle.
  - If pending=1, disp_reg<=shadow and pending<=0 in the same cycle.
- Load:
  - load=1 sets shadow<=value, pending<=1 in any state.
  - Back-to-back loads: last one wins.
  - load coincident with a frame boundary: disp_reg<=value (the new value) directly and pending<=0.
- IDLE with pending=1: disp_reg<=shadow immediately, since there is no tearing risk.
- en deasserted in any state: next cycle state=IDLE, anode_n all ones, idx=0, cnt=0, no frame_done. Shadow and pending are retained.
- Leading-zero blanking:
  - With blank_lz=1, digit i (i>=1) is blanked when disp_reg nibbles i..NUM_DIGITS-1 are all zero.
  - Blanked digits keep their full slot timing with anode_n held high.
  - Value 0 shows a single "0" on digit 0.
- rst mid-scan overrides everything, including a coincident load.
- Slot period = ON_CYCLES+DEAD_CYCLES; frame period = NUM_DIGITS*(ON_CYCLES+DEAD_CYCLES).
- cnt width = clog2(max(ON_CYCLES,DEAD_CYCLES)).

Decomposition:
- Package display_pkg:
  - scan_state_t enum (IDLE, ON, DEAD).
  - ANODES_OFF helper function returning all ones for a given width.
  - Default timing constants.
- One sub-module, slot_timer: loadable down-counter with terminal-count output, reused for the ON and DEAD intervals.
- Blanking mask and nibble mux stay inline.

Test Plan (NUM_DIGITS=4, ON_CYCLES=4, DEAD_CYCLES=2):
- Reset then en=1, load value=16'h12AF -> sequence per digit: digit=F with anode_n=1110 for 4 cycles, 2 cycles anode_n=1111 with digit=A, then anode_n=1101; frame_done pulses after digit 3's slot, every 24 cycles.
- blank_lz=1, value=16'h0050 -> digits 3 and 2 keep anode_n high for their slots; digits 1 (5) and 0 (0) are driven. value=16'h0000 -> only anode_n[0] asserts, digit=0.
- load 16'hBEEF mid-frame while showing 16'h1234 -> remaining digits of the current frame still show 1234; after frame_done, BEEF appears starting at digit 0.
- load 16'hCAFE on the exact frame_done cycle -> next frame shows CAFE; loads 16'h1111 then 16'h2222 in one frame -> 2222 shown.
- en dropped mid-ON on digit 2 -> next cycle anode_n=1111, no frame_done; en re-raised -> scan restarts at digit 0.
- rst asserted during DEAD together with load -> next cycle all outputs at reset values; disp_reg=0 and the load is discarded.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types, timing defaults and helpers for the multiplexed hex display.
package display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StDead
  } scan_state_t;

  localparam int unsigned MaxDigits          = 8;
  localparam int unsigned DefaultNumDigits   = 4;
  localparam int unsigned DefaultOnCycles    = 50000;
  localparam int unsigned DefaultDeadCycles  = 500;

  // All-ones anode pattern (every digit off) for the low 'width' bits.
  function automatic logic [MaxDigits-1:0] anodes_off(input int unsigned width);
    logic [MaxDigits-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxDigits; i++) begin
      if (i < width) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module slot_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins over load; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == '0);

endmodule

// File: rtl/hex_display_scanner.sv
// Scans a multi-digit hex value onto a shared 7-segment bus with dead-time between
// digits, optional leading-zero blanking and frame-aligned value updates.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = DefaultNumDigits,
  parameter int unsigned ON_CYCLES   = DefaultOnCycles,
  parameter int unsigned DEAD_CYCLES = DefaultDeadCycles
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [3:0]              digit,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_done
);

  localparam int unsigned IdxW      = $clog2(NUM_DIGITS);
  localparam int unsigned MaxCycles = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles);

  localparam logic [NUM_DIGITS-1:0] AllOff   = NUM_DIGITS'(anodes_off(NUM_DIGITS));
  localparam logic [IdxW-1:0]       LastIdx  = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0]       OnLoad   = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0]       DeadLoad = CntW'(DEAD_CYCLES - 1);

  scan_state_t             state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic [3:0]              digit_q, digit_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    frame_done_q, frame_done_d;

  logic            timer_clear, timer_load, tc;
  logic [CntW-1:0] timer_val, cnt;

  slot_timer #(
    .WIDTH(CntW)
  ) u_slot_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .load    (timer_load),
    .load_val(timer_val),
    .cnt     (cnt),
    .tc      (tc)
  );

  function automatic logic [3:0] nibble(input logic [4*NUM_DIGITS-1:0] v,
                                        input logic [IdxW-1:0] i);
    return 4'(v >> {i, 2'b00});
  endfunction

  // Anode pattern for digit i; digit i>=1 stays dark when it and all higher nibbles are zero.
  function automatic logic [NUM_DIGITS-1:0] drive(input logic [IdxW-1:0] i,
                                                  input logic [4*NUM_DIGITS-1:0] v,
                                                  input logic lz);
    logic [NUM_DIGITS-1:0] a;
    logic                  zero_above;
    logic                  blank;
    a          = AllOff;
    zero_above = 1'b1;
    blank      = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (v[4*k +: 4] == 4'h0);
      if (k == int'(i)) blank = lz && (k != 0) && zero_above;
    end
    if (!blank) a[i] = 1'b0;
    return a;
  endfunction

  // Scan FSM next-state, display-value commit and registered output values.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    digit_d      = digit_q;
    anode_d      = AllOff;
    frame_done_d = 1'b0;
    timer_clear  = 1'b0;
    timer_load   = 1'b0;
    timer_val    = OnLoad;

    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Nothing is being shown, so a pending value can be taken at once.
        if (pending_q) begin
          disp_d    = shadow_q;
          pending_d = load;
        end
        if (en) begin
          state_d    = StOn;
          idx_d      = '0;
          timer_load = 1'b1;
          timer_val  = OnLoad;
          digit_d    = nibble(disp_d, '0);
          anode_d    = drive('0, disp_d, blank_lz);
        end
      end
      StOn: begin
        if (tc) begin
          state_d    = StDead;
          timer_load = 1'b1;
          timer_val  = DeadLoad;
          if (idx_q == LastIdx) begin
            // Frame boundary: a coincident load bypasses the shadow.
            idx_d = '0;
            if (load) begin
              disp_d    = value;
              pending_d = 1'b0;
            end else if (pending_q) begin
              disp_d    = shadow_q;
              pending_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
          // Next nibble settles during the whole dead-time.
          digit_d = nibble(disp_d, idx_d);
        end else begin
          anode_d = drive(idx_q, disp_q, blank_lz);
          // Registered one cycle early so the pulse lines up with the boundary cycle.
          frame_done_d = (idx_q == LastIdx) && (cnt == CntW'(1));
        end
      end
      StDead: begin
        if (tc) begin
          state_d    = StOn;
          timer_load = 1'b1;
          timer_val  = OnLoad;
          anode_d    = drive(idx_q, disp_q, blank_lz);
        end
      end
      default: state_d = StIdle;
    endcase

    if (!en) begin
      state_d      = StIdle;
      idx_d        = '0;
      timer_clear  = 1'b1;
      timer_load   = 1'b0;
      anode_d      = AllOff;
      frame_done_d = 1'b0;
    end
  end

  // State and output registers; reset also discards a coincident load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      digit_q      <= 4'h0;
      anode_q      <= AllOff;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      digit_q      <= digit_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit      = digit_q;
  assign anode_n    = anode_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with NUM_DIGITS=4, ON_CYCLES=4, DEAD_CYCLES=2.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  anode_n;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  hex_display_scanner #(
    .NUM_DIGITS (4),
    .ON_CYCLES  (4),
    .DEAD_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .value     (value),
    .blank_lz  (blank_lz),
    .digit     (digit),
    .anode_n   (anode_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] d, input logic [3:0] an,
                         input logic fd);
    chk({tag, ".digit"}, {12'h0, digit}, {12'h0, d});
    chk({tag, ".anode"}, {12'h0, anode_n}, {12'h0, an});
    chk({tag, ".fd"}, {15'h0, frame_done}, {15'h0, fd});
  endtask

  // Called at the first ON cycle of a slot; returns at the first ON cycle of the next slot.
  // ld_k selects the ON cycle (0..3) in which a one-cycle load of ld_val is issued.
  task automatic run_slot(input string tag, input logic [3:0] d, input logic [3:0] an,
                          input logic [3:0] nd, input logic fd_last, input int ld_k,
                          input logic [15:0] ld_val);
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("%s.on%0d", tag, k), d, an, fd_last && (k == 3));
      if (k == ld_k) begin
        load  = 1'b1;
        value = ld_val;
      end
      tick();
      load = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      chk_out($sformatf("%s.dead%0d", tag, k), nd, 4'hF, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    value    = 16'h0;
    blank_lz = 1'b0;
    tick();
    tick();
    chk_out("reset", 4'h0, 4'hF, 1'b0);

    rst   = 1'b0;
    load  = 1'b1;
    value = 16'h12AF;
    tick();
    load = 1'b0;
    chk_out("idle_load", 4'h0, 4'hF, 1'b0);

    en = 1'b1;
    tick();
    // Frame 1: 12AF
    run_slot("f1s0", 4'hF, 4'hE, 4'hA, 1'b0, -1, 16'h0);
    run_slot("f1s1", 4'hA, 4'hD, 4'h2, 1'b0, -1, 16'h0);
    run_slot("f1s2", 4'h2, 4'hB, 4'h1, 1'b0, -1, 16'h0);
    run_slot("f1s3", 4'h1, 4'h7, 4'hF, 1'b1, -1, 16'h0);

    // Frame 2: 12AF still shown while 0050 waits in the shadow
    blank_lz = 1'b1;
    run_slot("f2s0", 4'hF, 4'hE, 4'hA, 1'b0, 0, 16'h0050);
    run_slot("f2s1", 4'hA, 4'hD, 4'h2, 1'b0, -1, 16'h0);
    run_slot("f2s2", 4'h2, 4'hB, 4'h1, 1'b0, -1, 16'h0);
    run_slot("f2s3", 4'h1, 4'h7, 4'h0, 1'b1, -1, 16'h0);

    // Frame 3: 0050 with leading-zero blanking
    run_slot("f3s0", 4'h0, 4'hE, 4'h5, 1'b0, 1, 16'h0000);
    run_slot("f3s1", 4'h5, 4'hD, 4'h0, 1'b0, -1, 16'h0);
    run_slot("f3s2", 4'h0, 4'hF, 4'h0, 1'b0, -1, 16'h0);
    run_slot("f3s3", 4'h0, 4'hF, 4'h0, 1'b1, -1, 16'h0);

    // Frame 4: 0000 shows a single zero on digit 0
    run_slot("f4s0", 4'h0, 4'hE, 4'h0, 1'b0, 0, 16'h1234);
    run_slot("f4s1", 4'h0, 4'hF, 4'h0, 1'b0, -1, 16'h0);
    run_slot("f4s2", 4'h0, 4'hF, 4'h0, 1'b0, -1, 16'h0);
    run_slot("f4s3", 4'h0, 4'hF, 4'h4, 1'b1, -1, 16'h0);

    // Frame 5: 1234; BEEF loaded mid-frame must not tear it
    blank_lz = 1'b0;
    run_slot("f5s0", 4'h4, 4'hE, 4'h3, 1'b0, -1, 16'h0);
    run_slot("f5s1", 4'h3, 4'hD, 4'h2, 1'b0, 2, 16'hBEEF);
    run_slot("f5s2", 4'h2, 4'hB, 4'h1, 1'b0, -1, 16'h0);
    run_slot("f5s3", 4'h1, 4'h7, 4'hF, 1'b1, -1, 16'h0);

    // Frame 6: BEEF; CAFE loaded on the frame_done cycle
    run_slot("f6s0", 4'hF, 4'hE, 4'hE, 1'b0, -1, 16'h0);
    run_slot("f6s1", 4'hE, 4'hD, 4'hE, 1'b0, -1, 16'h0);
    run_slot("f6s2", 4'hE, 4'hB, 4'hB, 1'b0, -1, 16'h0);
    run_slot("f6s3", 4'hB, 4'h7, 4'hE, 1'b1, 3, 16'hCAFE);

    // Frame 7: CAFE; two loads in one frame, the last one wins
    run_slot("f7s0", 4'hE, 4'hE, 4'hF, 1'b0, 0, 16'h1111);
    run_slot("f7s1", 4'hF, 4'hD, 4'hA, 1'b0, 0, 16'h2222);
    run_slot("f7s2", 4'hA, 4'hB, 4'hC, 1'b0, -1, 16'h0);
    run_slot("f7s3", 4'hC, 4'h7, 4'h2, 1'b1, -1, 16'h0);

    // Frame 8: 2222; en dropped during digit 2's ON time
    run_slot("f8s0", 4'h2, 4'hE, 4'h2, 1'b0, -1, 16'h0);
    run_slot("f8s1", 4'h2, 4'hD, 4'h2, 1'b0, -1, 16'h0);
    chk_out("f8s2.on0", 4'h2, 4'hB, 1'b0);
    tick();
    chk_out("f8s2.on1", 4'h2, 4'hB, 1'b0);
    en = 1'b0;
    tick();
    chk("en_drop.anode", {12'h0, anode_n}, 16'h000F);
    chk("en_drop.fd", {15'h0, frame_done}, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("idle%0d.anode", k), {12'h0, anode_n}, 16'h000F);
      chk($sformatf("idle%0d.fd", k), {15'h0, frame_done}, 16'h0000);
    end
    en = 1'b1;
    tick();
    run_slot("r_s0", 4'h2, 4'hE, 4'h2, 1'b0, -1, 16'h0);
    run_slot("r_s1", 4'h2, 4'hD, 4'h2, 1'b0, -1, 16'h0);
    chk_out("r_s2.on0", 4'h2, 4'hB, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk_out("r_s2.dead0", 4'h2, 4'hF, 1'b0);

    // Reset during DEAD together with a load: the load is discarded
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'h9999;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    chk_out("rst_dead", 4'h0, 4'hF, 1'b0);
    tick();
    chk_out("after_rst.on0", 4'h0, 4'hE, 1'b0);
    tick();
    chk_out("after_rst.on1", 4'h0, 4'hE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
